// File: rtl/seven_segment_scanner_if.sv
// Signal bundle between a display-value producer (master) and seven_segment_scanner (slave).
// Handshake: load is a one-cycle strobe with value/dp_in valid in the same cycle; there is no
// ready, the scanner always accepts, a newer load replaces an uncommitted one, and load_ack
// pulses exactly once when buffered data is committed at a frame boundary.
interface seven_segment_scanner_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IW = $clog2(NUM_DIGITS);

    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    load;
    logic [3:0]              num;
    logic [NUM_DIGITS-1:0]   anode;
    logic                    dp;
    logic                    load_ack;
    logic                    frame_done;
    logic                    dbg_state;
    logic [IW-1:0]           dbg_idx;
    logic                    dbg_pend_valid;

    modport master (
        output value, dp_in, digit_en, load,
        input  num, anode, dp, load_ack, frame_done,
        input  dbg_state, dbg_idx, dbg_pend_valid
    );

    modport slave (
        input  value, dp_in, digit_en, load,
        output num, anode, dp, load_ack, frame_done,
        output dbg_state, dbg_idx, dbg_pend_valid
    );
endinterface

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode display scanner with blanking gaps and frame-synchronous
// double buffering. Define SEVSEG_LZB_EN to enable leading-zero blanking.
module seven_segment_scanner #(
    parameter int NUM_DIGITS   = 4,
    parameter int ON_CYCLES    = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input logic                    clk,
    input logic                    reset,
    seven_segment_scanner_if.slave bus
);
    localparam int IW   = $clog2(NUM_DIGITS);
    localparam int CMAX = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0]         ON_LAST    = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [IW-1:0]         LAST_IDX   = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIGIT0     = NUM_DIGITS'(1);

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t                  state, nxt_state;
    logic [IW-1:0]           idx, nxt_idx;
    logic [CW-1:0]           cnt, nxt_cnt;
    logic [4*NUM_DIGITS-1:0] pend_val, shad_val;
    logic [NUM_DIGITS-1:0]   pend_dp, shad_dp;
    logic                    pend_valid;
    logic [3:0]              num_q;
    logic [NUM_DIGITS-1:0]   anode_q;
    logic                    dp_q;
    logic                    load_ack_q;
    logic                    frame_done_q;
    logic                    boundary;
    logic                    boundary_next;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   sup;
    logic [3:0]              nib [NUM_DIGITS];

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_nib
        assign nib[k] = shad_val[4*k +: 4];
    end

`ifdef SEVSEG_LZB_EN
    // A digit is dark when it and every digit to its left are zero; digit 0 always shows.
    logic upper_zero;
    always_comb begin
        sup        = '0;
        upper_zero = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            upper_zero = upper_zero && (shad_val[4*k +: 4] == 4'h0);
            sup[k]     = upper_zero;
        end
    end
`else
    assign sup = '0;
`endif

    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        nxt_cnt   = cnt + CW'(1);
        if (state == BLANK) begin
            if (cnt == BLANK_LAST) begin
                nxt_state = DRIVE;
                nxt_cnt   = '0;
            end
        end else if (cnt == ON_LAST) begin
            nxt_state = BLANK;
            nxt_cnt   = '0;
            nxt_idx   = (idx == LAST_IDX) ? '0 : idx + IW'(1);
        end
    end

    // frame_done is registered from the next-state view so it lines up with the boundary cycle.
    assign boundary      = (state == DRIVE) && (idx == LAST_IDX) && (cnt == ON_LAST);
    assign boundary_next = (nxt_state == DRIVE) && (nxt_idx == LAST_IDX) && (nxt_cnt == ON_LAST);
    assign lit           = (state == DRIVE) && bus.digit_en[idx] && !sup[idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= BLANK;
            idx          <= '0;
            cnt          <= '0;
            pend_val     <= '0;
            pend_dp      <= '0;
            pend_valid   <= 1'b0;
            shad_val     <= '0;
            shad_dp      <= '0;
            num_q        <= 4'h0;
            anode_q      <= '1;
            dp_q         <= 1'b1;
            load_ack_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state        <= nxt_state;
            idx          <= nxt_idx;
            cnt          <= nxt_cnt;
            num_q        <= nib[idx];
            anode_q      <= lit ? ~(DIGIT0 << idx) : '1;
            dp_q         <= lit ? ~shad_dp[idx] : 1'b1;
            frame_done_q <= boundary_next;
            load_ack_q   <= 1'b0;
            if (boundary && (pend_valid || bus.load)) begin
                // A load landing on the boundary bypasses the pending buffer.
                shad_val   <= bus.load ? bus.value : pend_val;
                shad_dp    <= bus.load ? bus.dp_in : pend_dp;
                pend_valid <= 1'b0;
                load_ack_q <= 1'b1;
            end else if (bus.load) begin
                pend_val   <= bus.value;
                pend_dp    <= bus.dp_in;
                pend_valid <= 1'b1;
            end
        end
    end

    assign bus.num            = num_q;
    assign bus.anode          = anode_q;
    assign bus.dp             = dp_q;
    assign bus.load_ack       = load_ack_q;
    assign bus.frame_done     = frame_done_q;
    assign bus.dbg_state      = state;
    assign bus.dbg_idx        = idx;
    assign bus.dbg_pend_valid = pend_valid;
endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Time-multiplexing controller that shares one `seven_segment_decoder` across `NUM_DIGITS` common-anode digits. It sequences a digit index, drives the decoder's 4-bit `num` input and the active-low anode/decimal-point lines, and inserts a blanking gap between digits to prevent ghosting. New display values are double-buffered and take effect only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
Parameters:
- `NUM_DIGITS`, 4: number of multiplexed digits, 2..8.
- `ON_CYCLES`, 100000: clock cycles each digit is driven per slot, at least 1.
- `BLANK_CYCLES`, 1000: clock cycles with all anodes off before each digit's drive phase, at least 1.

Ports:
- `clk`, input, 1: system clock, rising edge.
- `reset`, input, 1: synchronous, active-high.
- `value`, input, 4*NUM_DIGITS: nibble k is the hex digit for display position k (k=0 is rightmost).
- `dp_in`, input, NUM_DIGITS: decimal-point request per digit, 1 = lit.
- `digit_en`, input, NUM_DIGITS: per-digit enable; 0 keeps that digit dark. Sampled live, not buffered.
- `load`, input, 1: single-cycle strobe that captures `value` and `dp_in` into the pending buffer.
- `num`, output, 4: nibble to the decoder.
- `anode`, output, NUM_DIGITS: active-low digit selects.
- `dp`, output, 1: active-low decimal point.
- `load_ack`, output, 1: one-cycle pulse when pending data is committed to the shadow buffer.
- `frame_done`, output, 1: one-cycle pulse on the last cycle of the last digit's drive phase.

## Operation
- Registers: `pend_val`/`pend_dp`, `pend_valid`, `shad_val`/`shad_dp`, `idx` (0..NUM_DIGITS-1), `cnt`, and `state` ∈ {BLANK, DRIVE}.
- BLANK: all anode bits are 1, `dp`=1, and `num` = shadow nibble of `idx`. After BLANK_CYCLES cycles, `cnt` clears and the FSM moves to DRIVE.
- DRIVE: `anode[idx]`=0 if `digit_en[idx]`=1 (and, with the macro, the digit is not suppressed); all other anode bits are 1. `dp` = ~`shad_dp[idx]` while the anode is active, otherwise 1. After ON_CYCLES cycles the FSM moves to BLANK and `idx` increments, wrapping from NUM_DIGITS-1 to 0.
- Frame boundary: the last DRIVE cycle with `idx`=NUM_DIGITS-1. On that cycle `frame_done`=1. If `pend_valid`=1, the shadow buffer takes the pending buffer on the next edge, `load_ack` pulses for one cycle and `pend_valid` clears.
- `load`: the pending buffer takes the inputs and `pend_valid` is set. A `load` while `pend_valid`=1 overwrites the pending data; the latest load wins and only one ack is issued.
- `load` coinciding with a boundary cycle: the strobed inputs go directly into the shadow buffer, `load_ack` pulses and `pend_valid` ends at 0.
- `num` is a pure function of the registered `idx` and `shad_val`. `num`, `anode` and `dp` are all registered, with no combinational path from inputs to outputs.

## Timing
- Reset values: `anode`=all 1, `dp`=1, `num`=0, `load_ack`=0, `frame_done`=0. Internally: `idx`=0, `cnt`=0, `state`=BLANK, shadow and pending buffers all 0, `pend_valid`=0.
- The first anode goes low BLANK_CYCLES+1 edges after `reset` is deasserted.
- Digit slot length is BLANK_CYCLES+ON_CYCLES. Frame length is NUM_DIGITS×(BLANK_CYCLES+ON_CYCLES).
- Latency from `load` to display: from 1 cycle up to one frame. The new value appears from digit 0 onward in the frame after `load_ack`.
- Reset mid-frame: the next edge forces every reset value and discards any pending load without an ack.
- `digit_en` changes take effect at the next output register update.

## Configuration
- `SEVSEG_LZB_EN` defined: leading-zero blanking.
  - A digit k>0 is suppressed (anode held at 1, `dp` held at 1) when its shadow nibble and every nibble above it are 0.
  - Digit 0 is never suppressed.
  - The suppression mask is computed from the shadow buffer, so it changes only at frame boundaries.
- Undefined: every enabled digit is driven, including leading zeros. No suppression logic is synthesized.

## Test plan
All scenarios use NUM_DIGITS=4, ON_CYCLES=8, BLANK_CYCLES=2.
- Reset release -> anode=4'b1111 for 2 cycles, then 4'b1110 for 8 cycles, then 4'b1111 for 2 cycles, then 4'b1101. `frame_done` pulses every 40 cycles.
- `load` with value=16'h1234 mid-frame -> `load_ack` on the cycle after the next `frame_done`. Next frame: `num` = 4,3,2,1 for idx 0..3.
- Two `load`s (16'hAAAA, then 16'h5555) within one frame -> a single `load_ack`, and the display shows 5 in every digit.
- `load` with 16'h0042 on a boundary cycle -> `load_ack` on the next cycle and `pend_valid`=0. With `SEVSEG_LZB_EN`, anode bits 3 and 2 stay 1 all frame. Without it, digits 3 and 2 show 0.
- `digit_en`=4'b1010 and `dp_in`=4'b0001 -> anode[0] and anode[2] never go low, and `dp` stays 1 throughout (digit 0 is disabled).
- `reset` asserted during idx=2 DRIVE with `pend_valid`=1 -> next cycle all outputs are at reset values, and no `load_ack` occurs afterwards.
